// File: rtl/calc_sequencer.sv
// calc_sequencer: accumulator calculator with one-cycle add/sub and iterative shift-add multiply / restoring divide
module calc_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateType;
    stateType state, next;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] acc, opA, opB;
    logic [2*WIDTH-1:0] prod, mulNext, divNext;
    logic [WIDTH:0] asRes, mulSum, divShift, divDiff;
    logic accept, divZero, lastIter, divGe, ovReg, dbzReg;

    assign accept   = in_valid && in_ready;
    assign divZero  = funct[1] && funct[0] && operand_b == '0;
    assign opA      = funct[2] ? operand_a : (clear ? '0 : acc);
    assign asRes    = funct[0] ? {1'b0, opA} - {1'b0, operand_b} : {1'b0, opA} + {1'b0, operand_b};
    assign lastIter = cnt == CW'(1);
    // prod holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    assign mulSum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opB} : '0);
    assign mulNext  = {mulSum, prod[WIDTH-1:1]};
    assign divShift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, opB};
    assign divGe    = !divDiff[WIDTH];
    assign divNext  = {divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0], prod[WIDTH-2:0], divGe};

    assign in_ready    = state == IDLE;
    assign busy        = state == MUL || state == DIV;
    assign out_valid   = state == DONE;
    assign overflow    = out_valid && ovReg;
    assign div_by_zero = out_valid && dbzReg;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: if (accept) next = (!funct[1] || divZero) ? DONE : (funct[0] ? DIV : MUL);
            MUL, DIV: if (lastIter) next = DONE;
            DONE: if (out_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            cnt    <= '0;
            opB    <= '0;
            prod   <= '0;
            result <= '0;
            ovReg  <= 1'b0;
            dbzReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) acc <= '0;
                    if (accept) begin
                        opB    <= operand_b;
                        cnt    <= CW'(WIDTH);
                        prod   <= {{WIDTH{1'b0}}, opA};
                        ovReg  <= 1'b0;
                        dbzReg <= 1'b0;
                        if (!funct[1]) begin
                            result <= asRes[WIDTH-1:0];
                            ovReg  <= asRes[WIDTH];
                            acc    <= asRes[WIDTH-1:0];
                        end else if (divZero) begin
                            result <= '1;
                            dbzReg <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    prod <= mulNext;
                    cnt  <= cnt - 1'b1;
                    if (lastIter) begin
                        result <= mulNext[WIDTH-1:0];
                        ovReg  <= |mulNext[2*WIDTH-1:WIDTH];
                        acc    <= mulNext[WIDTH-1:0];
                    end
                end
                DIV: begin
                    prod <= divNext;
                    cnt  <= cnt - 1'b1;
                    if (lastIter) begin
                        result <= divNext[WIDTH-1:0];
                        acc    <= divNext[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed-vector bench for calc_sequencer at WIDTH = 8
module tb_calc_sequencer;
    logic clk = 0, reset = 1, in_valid = 0, clear = 0, out_ready = 0;
    logic in_ready, out_valid, overflow, div_by_zero, busy;
    logic [2:0] funct = 0;
    logic [7:0] operand_a = 0, operand_b = 0, result;
    int vectors = 0, miscompares = 0;

    calc_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .funct(funct),
        .operand_a(operand_a), .operand_b(operand_b), .clear(clear), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .overflow(overflow), .div_by_zero(div_by_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // Drives one request, scrambles the inputs after the accept edge, and counts
    // edges following the accept edge until out_valid (0 = done at the accept edge).
    task automatic issue(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b, input logic c,
                         output int lat, output logic allBusy);
        @(negedge clk);
        in_valid = 1; funct = f; operand_a = a; operand_b = b; clear = c;
        @(posedge clk); #1;
        in_valid = 0; clear = 1; funct = 3'b111; operand_a = 8'hA5; operand_b = 8'h00;
        lat = 0; allBusy = 1;
        while (!out_valid && lat < 40) begin
            allBusy &= busy;
            @(posedge clk); #1;
            lat++;
        end
        clear = 0;
    endtask

    task automatic ack();
        @(negedge clk); out_ready = 1;
        @(posedge clk); #1; out_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if ({in_ready, out_valid, busy, overflow, div_by_zero} !== 5'b10000) begin miscompares++; $display("FAIL reset_ctrl: got %b expected 10000", {in_ready, out_valid, busy, overflow, div_by_zero}); end
        vectors++; if (result !== 8'd0) begin miscompares++; $display("FAIL reset_result: got %0d expected 0", result); end
        @(negedge clk); reset = 0;
        @(posedge clk); #1;
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_no_request: in_ready %b out_valid %b expected 1 0", in_ready, out_valid); end
    endtask

    task automatic test_add();
        int lat; logic ab;
        issue(3'b100, 8'd200, 8'd100, 0, lat, ab);
        vectors++; if (lat !== 0) begin miscompares++; $display("FAIL add_latency: got %0d expected 0", lat); end
        vectors++; if (result !== 8'd44 || overflow !== 1'b1) begin miscompares++; $display("FAIL add_200_100: got %0d ov %b expected 44 ov 1", result, overflow); end
        ack();
    endtask

    task automatic test_sub_acc();
        int lat; logic ab;
        issue(3'b101, 8'd5, 8'd7, 0, lat, ab);
        vectors++; if (result !== 8'd254 || overflow !== 1'b1) begin miscompares++; $display("FAIL sub_5_7: got %0d ov %b expected 254 ov 1", result, overflow); end
        ack();
        issue(3'b000, 8'd77, 8'd3, 0, lat, ab);
        vectors++; if (result !== 8'd1 || overflow !== 1'b1) begin miscompares++; $display("FAIL acc_add_3: got %0d ov %b expected 1 ov 1", result, overflow); end
        ack();
    endtask

    task automatic test_mul();
        int lat; logic ab;
        issue(3'b110, 8'd12, 8'd13, 0, lat, ab);
        vectors++; if (lat !== 8) begin miscompares++; $display("FAIL mul_latency: got %0d expected 8", lat); end
        vectors++; if (ab !== 1'b1) begin miscompares++; $display("FAIL mul_busy: got %b expected 1", ab); end
        vectors++; if (result !== 8'd156 || overflow !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mul_12_13: got %0d ov %b busy %b expected 156 ov 0 busy 0", result, overflow, busy); end
        ack();
        issue(3'b110, 8'd20, 8'd20, 0, lat, ab);
        vectors++; if (result !== 8'd144 || overflow !== 1'b1) begin miscompares++; $display("FAIL mul_20_20: got %0d ov %b expected 144 ov 1", result, overflow); end
        ack();
    endtask

    task automatic test_div();
        int lat; logic ab;
        issue(3'b111, 8'd100, 8'd7, 0, lat, ab);
        vectors++; if (lat !== 8) begin miscompares++; $display("FAIL div_latency: got %0d expected 8", lat); end
        vectors++; if (result !== 8'd14 || overflow !== 1'b0 || div_by_zero !== 1'b0) begin miscompares++; $display("FAIL div_100_7: got %0d ov %b dz %b expected 14 0 0", result, overflow, div_by_zero); end
        ack();
        issue(3'b011, 8'd0, 8'd0, 0, lat, ab);
        vectors++; if (lat !== 0) begin miscompares++; $display("FAIL divzero_latency: got %0d expected 0", lat); end
        vectors++; if (result !== 8'd255 || div_by_zero !== 1'b1 || overflow !== 1'b0) begin miscompares++; $display("FAIL divzero: got %0d dz %b ov %b expected 255 1 0", result, div_by_zero, overflow); end
        ack();
        vectors++; if (div_by_zero !== 1'b0 || out_valid !== 1'b0 || result !== 8'd255) begin miscompares++; $display("FAIL divzero_after_ack: dz %b ov_valid %b result %0d expected 0 0 255", div_by_zero, out_valid, result); end
        issue(3'b000, 8'd0, 8'd0, 0, lat, ab);
        vectors++; if (result !== 8'd14) begin miscompares++; $display("FAIL acc_kept_after_divzero: got %0d expected 14", result); end
        ack();
        issue(3'b000, 8'd0, 8'd9, 1, lat, ab);
        vectors++; if (result !== 8'd9 || overflow !== 1'b0) begin miscompares++; $display("FAIL clear_add_9: got %0d ov %b expected 9 ov 0", result, overflow); end
        ack();
    endtask

    task automatic test_hold();
        int lat; logic ab;
        issue(3'b100, 8'd3, 8'd4, 0, lat, ab);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++; if ({out_valid, in_ready, overflow, div_by_zero, result} !== {4'b1000, 8'd7}) begin miscompares++; $display("FAIL hold_cycle%0d: got %b expected 1000_00000111", i, {out_valid, in_ready, overflow, div_by_zero, result}); end
        end
        ack();
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release: in_ready %b out_valid %b expected 1 0", in_ready, out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        int lat; logic ab;
        @(negedge clk);
        in_valid = 1; funct = 3'b110; operand_a = 8'd12; operand_b = 8'd13;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_mul_busy: got %b expected 1", busy); end
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        vectors++; if ({out_valid, busy, in_ready} !== 3'b001) begin miscompares++; $display("FAIL reset_mid_mul: got %b expected 001", {out_valid, busy, in_ready}); end
        issue(3'b000, 8'd0, 8'd0, 0, lat, ab);
        vectors++; if (result !== 8'd0 || overflow !== 1'b0) begin miscompares++; $display("FAIL acc_zero_after_reset: got %0d ov %b expected 0 ov 0", result, overflow); end
        ack();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_acc();
        test_mul();
        test_div();
        test_hold();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, operand/result/accumulator width in bits; SHALL be >= 2.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request present on funct/operand_a/operand_b.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 funct  input  3  bit2: 1 = use operand_a, 0 = use accumulator as A; bits1:0: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 operand_a  input  WIDTH  first operand, unsigned.
REQ-008 operand_b  input  WIDTH  second operand, unsigned.
REQ-009 clear  input  1  zero the accumulator.
REQ-010 out_valid  output  1  result and flags are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 overflow  output  1  carry/borrow or product high bits nonzero.
REQ-014 div_by_zero  output  1  divide with B == 0.
REQ-015 busy  output  1  state is MUL or DIV.

Function
REQ-016 The block SHALL implement states IDLE, MUL, DIV and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; a request SHALL be accepted on an edge where in_valid and in_ready are both 1.
REQ-018 Operand A SHALL be operand_a when funct[2]=1; otherwise it SHALL be the accumulator, sampled at the accept edge.
REQ-019 clear SHALL take effect only in IDLE; when clear and an accepted request coincide, the accumulator SHALL be treated as 0 for that request.
REQ-020 Add/sub: IDLE->DONE on the accept edge; latency 1 cycle; result = (A +/- B) mod 2^WIDTH; overflow = carry-out (add) or borrow (sub, A < B).
REQ-021 Mul: IDLE->MUL on accept, counter loaded with WIDTH; one shift-add iteration per cycle; MUL->DONE on the WIDTH-th following edge (latency WIDTH cycles); result = low WIDTH bits of A*B; overflow = 1 iff the high WIDTH bits are nonzero.
REQ-022 Div: same timing as mul using restoring division; result = floor(A/B); overflow = 0.
REQ-023 Div with B == 0: IDLE->DONE on the accept edge (latency 1); result = all ones; div_by_zero = 1; overflow = 0.
REQ-024 Operands and partial results SHALL be internally registered; input changes after the accept edge SHALL NOT affect the operation.
REQ-025 On entry to DONE the accumulator SHALL be loaded with result, except on divide-by-zero, where it SHALL be unchanged.
REQ-026 In DONE, out_valid = 1 and result/overflow/div_by_zero SHALL be held stable until an edge with out_ready = 1, which SHALL return the block to IDLE.
REQ-027 There is no back-to-back acceptance: the minimum period between accepts is latency + 1 cycles.
REQ-028 out_valid, overflow and div_by_zero SHALL be 0 outside DONE; result SHALL hold its last value outside DONE.
REQ-029 funct, operand_a and operand_b SHALL be ignored when in_valid = 0 or in_ready = 0.

Reset
REQ-030 While reset = 1 at an edge: state = IDLE; accumulator, counter, result, overflow, div_by_zero, out_valid and busy SHALL all be 0; in_ready = 1 from the following cycle.
REQ-031 Reset SHALL override every other input in any state, including mid-MUL/DIV; any operation in progress SHALL be discarded without updating the accumulator.

Verification (WIDTH = 8)
REQ-032 funct=100, A=200, B=100 -> out_valid 1 cycle after accept; result 44; overflow 1.
REQ-033 funct=101, A=5, B=7 -> result 254, overflow 1; then funct=000, B=3 -> result 1, overflow 1; accumulator 1.
REQ-034 funct=110, A=12, B=13 -> out_valid exactly 8 cycles after accept, result 156, overflow 0, busy 1 throughout MUL; then A=20, B=20 -> result 144, overflow 1.
REQ-035 funct=111, A=100, B=7 -> result 14 after 8 cycles; then funct=011, B=0 -> result 255, div_by_zero 1 after 1 cycle; accumulator remains 14; then clear with funct=000, B=9 -> result 9.
REQ-036 Hold out_ready = 0 for 5 cycles in DONE -> out_valid, result and flags stable and in_ready 0; out_ready = 1 -> IDLE next cycle.
REQ-037 Assert reset in the 3rd cycle of MUL -> next cycle state IDLE, out_valid 0, busy 0, in_ready 1, accumulator 0.
